// File: rtl/sap_datapath.sv
// sap_datapath: bus-structured datapath for the 8-bit SAP computer.
//
// PC, MAR, 16x8 RAM, IR, A, B, ALU with latched op, Z/C flags and an output
// register share one 8-bit internal bus driven under a 17-bit control word.
// All registers update on the rising edge; the control unit changes the
// word on the falling edge, so every micro-step is one clock.
//
// RAM is not touched by reset. While rst is high it can be preloaded via
// prog_we/prog_addr/prog_data, and bus-sourced RAM writes are suppressed.
//
// Build option: define SAP_BUS_CHECK_EN to build the sticky multiple-driver
// checker behind bus_conflict. Without it bus_conflict is tied low. Bus
// priority resolution is the same in both builds.

module sap_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] ControlSignal,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic [3:0]  opcode,
    output logic [1:0]  flagReg,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        bus_conflict
);

    // Control word bit positions
    localparam int CW_RAM_WE  = 0;
    localparam int CW_RAM_OUT = 1;
    localparam int CW_PC_LD   = 2;
    localparam int CW_PC_OUT  = 3;
    localparam int CW_IR_LD   = 4;
    localparam int CW_OUT_LD  = 5;
    localparam int CW_MAR_LD  = 6;
    localparam int CW_IR_OUT  = 7;
    localparam int CW_PC_INC  = 8;
    localparam int CW_B_LD    = 9;
    localparam int CW_A_OUT   = 10;
    localparam int CW_A_LDI   = 11;
    localparam int CW_A_LD    = 12;
    localparam int CW_OP_LO   = 13;
    localparam int CW_OP_HI   = 14;
    localparam int CW_ALU_OUT = 15;
    localparam int CW_FLAG_T  = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    // Architectural registers
    logic [3:0] r_pc;
    logic [3:0] r_mar;
    logic [7:0] r_ir;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_out;
    logic [1:0] r_alu_op;
    logic       r_flag_z;
    logic       r_flag_c;
    logic       r_out_valid;
    logic [7:0] r_ram [16];

    // Decoded control strobes
    logic w_ram_we;
    logic w_ram_out;
    logic w_pc_ld;
    logic w_pc_out;
    logic w_ir_ld;
    logic w_out_ld;
    logic w_mar_ld;
    logic w_ir_out;
    logic w_pc_inc;
    logic w_b_ld;
    logic w_a_out;
    logic w_a_ldi;
    logic w_a_ld;
    logic w_alu_out;
    logic w_op_ld;
    logic [1:0] w_op_sel;

    // Bit 16 is the control unit's flag-test strobe; the datapath has no use for it.
    logic w_unused;

    logic [7:0] w_ram_rd;
    logic [8:0] w_alu;
    logic [7:0] w_bus;

    assign w_ram_we  = ControlSignal[CW_RAM_WE];
    assign w_ram_out = ControlSignal[CW_RAM_OUT];
    assign w_pc_ld   = ControlSignal[CW_PC_LD];
    assign w_pc_out  = ControlSignal[CW_PC_OUT];
    assign w_ir_ld   = ControlSignal[CW_IR_LD];
    assign w_out_ld  = ControlSignal[CW_OUT_LD];
    assign w_mar_ld  = ControlSignal[CW_MAR_LD];
    assign w_ir_out  = ControlSignal[CW_IR_OUT];
    assign w_pc_inc  = ControlSignal[CW_PC_INC];
    assign w_b_ld    = ControlSignal[CW_B_LD];
    assign w_a_out   = ControlSignal[CW_A_OUT];
    assign w_a_ldi   = ControlSignal[CW_A_LDI];
    assign w_a_ld    = ControlSignal[CW_A_LD];
    assign w_alu_out = ControlSignal[CW_ALU_OUT];
    assign w_op_sel  = ControlSignal[CW_OP_HI:CW_OP_LO];
    assign w_unused  = ControlSignal[CW_FLAG_T];

    // The op latch follows the word whenever B is loaded or an op is named,
    // so a later ALU-out word with bits 14:13 clear reuses the earlier op.
    assign w_op_ld = w_b_ld | ControlSignal[CW_OP_LO] | ControlSignal[CW_OP_HI];

    // Asynchronous RAM read at the current MAR
    assign w_ram_rd = r_ram[r_mar];

    // 9-bit ALU; bit 8 is the carry out
    always_comb begin
        w_alu = 9'd0;
        unique case (r_alu_op)
            OP_ADD: w_alu = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB: w_alu = {1'b0, r_a} + {1'b0, ~r_b} + 9'd1;
            OP_INC: w_alu = {1'b0, r_a} + 9'd1;
            OP_DEC: w_alu = {1'b0, r_a} + 9'h0FF;
            default: w_alu = 9'd0;
        endcase
    end

    // Bus mux with fixed priority ALU > A > RAM > IR > PC; idle bus reads 0
    always_comb begin
        w_bus = 8'h00;
        if (w_alu_out) begin
            w_bus = w_alu[7:0];
        end else if (w_a_out) begin
            w_bus = r_a;
        end else if (w_ram_out) begin
            w_bus = w_ram_rd;
        end else if (w_ir_out) begin
            w_bus = {4'h0, r_ir[3:0]};
        end else if (w_pc_out) begin
            w_bus = {4'h0, r_pc};
        end
    end

    // Program counter: load beats increment, increment wraps 15 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= 4'h0;
        end else if (w_pc_ld) begin
            r_pc <= w_bus[3:0];
        end else if (w_pc_inc) begin
            r_pc <= r_pc + 4'h1;
        end
    end

    // Plain bus-loaded registers: MAR, IR, B, OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mar <= 4'h0;
            r_ir  <= 8'h00;
            r_b   <= 8'h00;
            r_out <= 8'h00;
        end else begin
            if (w_mar_ld) r_mar <= w_bus[3:0];
            if (w_ir_ld)  r_ir  <= w_bus;
            if (w_b_ld)   r_b   <= w_bus;
            if (w_out_ld) r_out <= w_bus;
        end
    end

    // Accumulator: full load beats load-immediate (low nibble, zero-extended)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= 8'h00;
        end else if (w_a_ld) begin
            r_a <= w_bus;
        end else if (w_a_ldi) begin
            r_a <= {4'h0, w_bus[3:0]};
        end
    end

    // ALU operation latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op <= OP_ADD;
        end else if (w_op_ld) begin
            r_alu_op <= w_op_sel;
        end
    end

    // Z/C capture only when the ALU result is placed on the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_alu_out) begin
            r_flag_z <= (w_alu[7:0] == 8'h00);
            r_flag_c <= w_alu[8];
        end
    end

    // Output strobe: high for the cycle after every OUT load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_out_ld;
        end
    end

    // RAM write port: program port during reset, bus writes otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            if (prog_we) r_ram[prog_addr] <= prog_data;
        end else if (w_ram_we) begin
            r_ram[r_mar] <= w_bus;
        end
    end

`ifdef SAP_BUS_CHECK_EN
    logic [2:0] w_drv_cnt;
    logic       r_bus_conflict;

    assign w_drv_cnt = {2'b00, w_alu_out} + {2'b00, w_a_out} + {2'b00, w_ram_out}
                     + {2'b00, w_ir_out} + {2'b00, w_pc_out};

    // Sticky flag for any edge with more than one bus driver; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_conflict <= 1'b0;
        end else if (w_drv_cnt > 3'd1) begin
            r_bus_conflict <= 1'b1;
        end
    end

    assign bus_conflict = r_bus_conflict;
`else
    assign bus_conflict = 1'b0;
`endif

    assign opcode    = r_ir[7:4];
    assign flagReg   = {r_flag_z, r_flag_c};
    assign out_data  = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath. Internal registers are observed through
// the output register (PC out / A out / RAM out / IR out combined with OUT
// load); each expected output byte is queued when the word is driven and
// popped when out_valid shows up.

module tb_sap_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] ControlSignal;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [1:0]  flagReg;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        bus_conflict;

    int         n_pass  = 0;
    int         n_total = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_q[$];

`ifdef SAP_BUS_CHECK_EN
    localparam logic EXP_CONF = 1'b1;
`else
    localparam logic EXP_CONF = 1'b0;
`endif

    sap_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .ControlSignal(ControlSignal),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .flagReg      (flagReg),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .bus_conflict (bus_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // Drive one control word for one micro-step and check the output strobe
    task automatic step(input logic [16:0] cw);
        logic [7:0] e;
        @(negedge clk);
        ControlSignal = cw;
        @(posedge clk);
        #1;
        exp_valid = cw[5];
        chk("out_valid", {7'd0, out_valid}, {7'd0, exp_valid});
        if (exp_valid) begin
            n_total++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL scoreboard: observed empty queue expected pending entry");
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
            end
        end
    endtask

    task automatic out_expect(input logic [16:0] cw, input logic [7:0] exp);
        exp_q.push_back(exp);
        step(cw);
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
    endtask

    initial begin
        rst           = 1'b1;
        ControlSignal = 17'h0;
        prog_we       = 1'b0;
        prog_addr     = 4'h0;
        prog_data     = 8'h00;

        // Preload program/data while in reset
        prog(4'h0, 8'h1E);
        prog(4'h1, 8'h05);
        prog(4'h2, 8'h03);
        prog(4'h3, 8'h05);
        prog(4'h4, 8'h00);
        prog(4'h7, 8'h8C);
        prog(4'hC, 8'hA7);
        prog(4'hE, 8'hFB);
        @(negedge clk);
        prog_we = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_opcode",   {4'h0, opcode},       8'h00);
        chk("rst_flags",    {6'd0, flagReg},      8'h00);
        chk("rst_out_data", out_data,             8'h00);
        chk("rst_valid",    {7'd0, out_valid},    8'h00);
        chk("rst_conflict", {7'd0, bus_conflict}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Fetch: MAR <- PC, then IR <- RAM[MAR] with PC+1
        step(17'h00048);
        step(17'h00112);
        chk("fetch_opcode", {4'h0, opcode}, 8'h01);
        out_expect(17'h000A0, 8'h0E);
        out_expect(17'h00028, 8'h01);
        out_expect(17'h00022, 8'h1E);

        // Add 05 + FB -> 00 with Z and C
        step(17'h00048);
        step(17'h01002);
        step(17'h000C0);
        step(17'h00202);
        step(17'h09000);
        chk("add_flags", {6'd0, flagReg}, 8'h03);
        out_expect(17'h00420, 8'h00);

        // Subtract 03 - 05 -> FE, no flags
        step(17'h00100);
        step(17'h00048);
        step(17'h01002);
        step(17'h00100);
        step(17'h00048);
        step(17'h02202);
        step(17'h09000);
        chk("sub_flags", {6'd0, flagReg}, 8'h00);
        out_expect(17'h00420, 8'hFE);

        // Decrement 00 -> FF, then increment FF -> 00 with Z and C
        step(17'h00100);
        step(17'h00048);
        step(17'h01002);
        step(17'h06000);
        step(17'h09000);
        chk("dec_flags", {6'd0, flagReg}, 8'h00);
        out_expect(17'h00420, 8'hFF);
        step(17'h04000);
        step(17'h09000);
        chk("inc_flags", {6'd0, flagReg}, 8'h03);
        out_expect(17'h00420, 8'h00);

        // Jump and PC rules
        step(17'h00100);
        step(17'h00100);
        step(17'h00100);
        step(17'h00048);
        step(17'h00012);
        chk("jmp_opcode", {4'h0, opcode}, 8'h08);
        step(17'h00084);
        out_expect(17'h00028, 8'h0C);
        step(17'h00184);
        out_expect(17'h00028, 8'h0C);
        step(17'h00100);
        step(17'h00100);
        step(17'h00100);
        out_expect(17'h00028, 8'h0F);
        step(17'h00100);
        out_expect(17'h00028, 8'h00);

        // Load immediate, store, output
        step(17'h000C0);
        step(17'h00012);
        chk("ldi_opcode", {4'h0, opcode}, 8'h0A);
        step(17'h00880);
        step(17'h00100);
        step(17'h00100);
        step(17'h00100);
        step(17'h00048);
        step(17'h00401);
        out_expect(17'h00022, 8'h07);
        out_expect(17'h00420, 8'h07);
        step(17'h00000);
        chk("out_hold", out_data, 8'h07);
        chk("pre_conflict", {7'd0, bus_conflict}, 8'h00);

        // Conflicts and bus priority
        step(17'h00402);
        chk("conflict_set", {7'd0, bus_conflict}, {7'd0, EXP_CONF});
        step(17'h00048);
        chk("conflict_sticky", {7'd0, bus_conflict}, {7'd0, EXP_CONF});
        out_expect(17'h08420, 8'h08);
        chk("prio_flags", {6'd0, flagReg}, 8'h00);
        out_expect(17'h000A8, 8'h07);

        // One-cycle reset with an attempted RAM write that must be ignored
        @(negedge clk);
        rst = 1'b1;
        ControlSignal = 17'h00001;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        ControlSignal = 17'h0;
        exp_valid = 1'b0;
        chk("rst2_opcode",   {4'h0, opcode},       8'h00);
        chk("rst2_flags",    {6'd0, flagReg},      8'h00);
        chk("rst2_out_data", out_data,             8'h00);
        chk("rst2_valid",    {7'd0, out_valid},    8'h00);
        chk("rst2_conflict", {7'd0, bus_conflict}, 8'h00);
        out_expect(17'h00028, 8'h00);
        out_expect(17'h00420, 8'h00);
        out_expect(17'h00022, 8'h1E);
        step(17'h00100);
        step(17'h00100);
        step(17'h00100);
        step(17'h00048);
        out_expect(17'h00022, 8'h07);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
